sync_ram_param: RTL and testbench

//   Parametrised single-port synchronous RAM; successor to the fixed 5x128 RAM.

---
 rtl/sync_ram_param_if.sv | 25 ++
 rtl/sync_ram_param.sv | 132 +++++++++++++
 tb/tb_sync_ram_param.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_ram_param_if.sv
// Request/response bundle for sync_ram_param: the requester drives write/read/address/data_in,
// and the RAM returns data_out with its rd_valid, busy and err strobes.
interface sync_ram_param_if #(
  parameter int DATA_WIDTH = 5,
  parameter int ADDR_WIDTH = 7
);
  logic                  write;
  logic                  read;
  logic [DATA_WIDTH-1:0] data_in;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic                  busy;
  logic                  err;

  modport master (
    output write, read, data_in, address,
    input  data_out, rd_valid, busy, err
  );

  modport slave (
    input  write, read, data_in, address,
    output data_out, rd_valid, busy, err
  );
endinterface

// File: rtl/sync_ram_param.sv
// Parametrised single-port synchronous RAM with a post-reset clear sweep, a 1- or
// 2-cycle pipelined read path with a valid strobe, and an error strobe for illegal requests.
module sync_ram_param #(
  parameter int DATA_WIDTH     = 5,
  parameter int ADDR_WIDTH     = 7,
  parameter int DEPTH          = 128,
  parameter int RD_LATENCY     = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  sync_ram_param_if.slave    bus
);
  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  // One extra bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(DEPTH - 1);
  localparam state_t                RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  state_t                r_state, w_state_next;
  logic [ADDR_WIDTH-1:0] r_clr_addr, w_clr_addr_next;
  logic                  w_addr_ok, w_any_req;
  logic                  w_we, w_rd_acc, w_err_next;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata;

  logic [DATA_WIDTH-1:0] r_mem_q;
  logic                  r_oor_q, r_vld_q;
  logic [DATA_WIDTH-1:0] w_stage0_data, w_last_data;
  logic                  w_last_vld;

  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_rd_valid, r_err;

  assign w_addr_ok = ({1'b0, bus.address} < DEPTH_EXT);
  assign w_any_req = bus.write | bus.read;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= RESET_STATE;
      r_clr_addr <= '0;
    end else begin
      r_state    <= w_state_next;
      r_clr_addr <= w_clr_addr_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_clr_addr_next = r_clr_addr;
    w_we            = 1'b0;
    w_waddr         = bus.address;
    w_wdata         = bus.data_in;
    w_rd_acc        = 1'b0;
    w_err_next      = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_we            = 1'b1;
        w_waddr         = r_clr_addr;
        w_wdata         = '0;
        w_clr_addr_next = r_clr_addr + 1'b1;
        w_err_next      = w_any_req;
        if (r_clr_addr == LAST_ADDR) w_state_next = ST_IDLE;
      end
      ST_IDLE: begin
        w_we       = bus.write & w_addr_ok;
        w_rd_acc   = bus.read & ~bus.write;
        w_err_next = (bus.write & bus.read) | (w_any_req & ~w_addr_ok);
      end
      default: w_state_next = RESET_STATE;
    endcase
  end

  // Storage and its read register carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (reset && w_we) r_mem[w_waddr] <= w_wdata;
    if (w_rd_acc && w_addr_ok) r_mem_q <= r_mem[bus.address];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_vld_q <= 1'b0;
      r_oor_q <= 1'b0;
    end else begin
      r_vld_q <= w_rd_acc;
      if (w_rd_acc) r_oor_q <= ~w_addr_ok;
    end
  end

  assign w_stage0_data = r_oor_q ? '0 : r_mem_q;

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] r_data_p;
      logic                  r_vld_p;
      always_ff @(posedge clk) begin
        if (!reset) begin
          r_vld_p  <= 1'b0;
          r_data_p <= '0;
        end else begin
          r_vld_p  <= r_vld_q;
          r_data_p <= w_stage0_data;
        end
      end
      assign w_last_data = r_data_p;
      assign w_last_vld  = r_vld_p;
    end else begin : g_lat1
      assign w_last_data = w_stage0_data;
      assign w_last_vld  = r_vld_q;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_data_out <= '0;
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_rd_valid <= w_last_vld;
      r_err      <= w_err_next;
      if (w_last_vld) r_data_out <= w_last_data;
    end
  end

  assign bus.data_out = r_data_out;
  assign bus.rd_valid = r_rd_valid;
  assign bus.err      = r_err;
  assign bus.busy     = (r_state == ST_CLEAR);
endmodule

// File: tb/tb_sync_ram_param.sv
// Bench for sync_ram_param: instance A (128 words, 1-cycle read) and instance B (100 words,
// 2-cycle read) are driven by scenario tasks and checked against array/queue reference models.
module tb_sync_ram_param;
  localparam int DW = 5;
  localparam int AW = 7;
  localparam int DEPTH_A = 128;
  localparam int DEPTH_B = 100;
  localparam int LAT_A = 1;
  localparam int LAT_B = 2;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  int tests_run = 0;
  int tests_failed = 0;

  logic [DW-1:0] ma [DEPTH_A];
  logic [DW-1:0] mb [DEPTH_B];

  sync_ram_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_a ();
  sync_ram_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_b ();

  sync_ram_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH_A),
                   .RD_LATENCY(LAT_A), .CLEAR_ON_RESET(1'b1))
    dut_a (.clk(clk), .reset(rst_a), .bus(bus_a));

  sync_ram_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH_B),
                   .RD_LATENCY(LAT_B), .CLEAR_ON_RESET(1'b1))
    dut_b (.clk(clk), .reset(rst_b), .bus(bus_b));

  always #5 clk = ~clk;

  task automatic set_a(input logic w, input logic r, input logic [AW-1:0] addr, input logic [DW-1:0] d);
    bus_a.write = w; bus_a.read = r; bus_a.address = addr; bus_a.data_in = d;
  endtask

  task automatic set_b(input logic w, input logic r, input logic [AW-1:0] addr, input logic [DW-1:0] d);
    bus_b.write = w; bus_b.read = r; bus_b.address = addr; bus_b.data_in = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int done_a = 0;
    int done_b = 0;
    @(negedge clk); rst_a = 1'b0; rst_b = 1'b0;
    set_a(1'b1, 1'b0, 7'd3, 5'h1f); set_b(1'b0, 1'b1, 7'd4, 5'h00);
    step();
    tests_run++;
    if ({bus_a.busy, bus_a.rd_valid, bus_a.err, bus_a.data_out} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin
      tests_failed++;
      $display("FAIL reset_outputs_a: got busy/rdv/err/dout=%b/%b/%b/%h expected 1/0/0/00",
               bus_a.busy, bus_a.rd_valid, bus_a.err, bus_a.data_out);
    end
    tests_run++;
    if ({bus_b.busy, bus_b.err} !== 2'b10) begin
      tests_failed++;
      $display("FAIL reset_outputs_b: got busy/err=%b/%b expected 1/0", bus_b.busy, bus_b.err);
    end
    @(negedge clk); set_a(1'b0, 1'b0, 7'd0, 5'd0); set_b(1'b0, 1'b0, 7'd0, 5'd0);
    step();
    @(negedge clk); rst_a = 1'b1; rst_b = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      step();
      if (!bus_a.busy && done_a == 0) done_a = n;
      if (!bus_b.busy && done_b == 0) done_b = n;
      if (done_a != 0 && done_b != 0) break;
    end
    tests_run++;
    if (done_a != DEPTH_A) begin
      tests_failed++;
      $display("FAIL clear_len_a: busy fell after %0d edges expected %0d", done_a, DEPTH_A);
    end
    tests_run++;
    if (done_b != DEPTH_B) begin
      tests_failed++;
      $display("FAIL clear_len_b: busy fell after %0d edges expected %0d", done_b, DEPTH_B);
    end
    foreach (ma[i]) ma[i] = '0;
    foreach (mb[i]) mb[i] = '0;
    // Sweep every address of both instances with back-to-back reads.
    for (int i = 0; i <= DEPTH_A; i++) begin
      @(negedge clk);
      set_a(1'b0, i < DEPTH_A, AW'(i), 5'd0);
      set_b(1'b0, i < DEPTH_B, AW'(i), 5'd0);
      step();
      if (i >= LAT_A && i - LAT_A < DEPTH_A) begin
        tests_run++;
        if ({bus_a.rd_valid, bus_a.data_out} !== {1'b1, ma[i-LAT_A]}) begin
          tests_failed++;
          $display("FAIL clear_read_a[%0d]: got rdv=%b dout=%h expected rdv=1 dout=%h",
                   i - LAT_A, bus_a.rd_valid, bus_a.data_out, ma[i-LAT_A]);
        end
      end
      if (i >= LAT_B && i - LAT_B < DEPTH_B) begin
        tests_run++;
        if ({bus_b.rd_valid, bus_b.data_out} !== {1'b1, mb[i-LAT_B]}) begin
          tests_failed++;
          $display("FAIL clear_read_b[%0d]: got rdv=%b dout=%h expected rdv=1 dout=%h",
                   i - LAT_B, bus_b.rd_valid, bus_b.data_out, mb[i-LAT_B]);
        end
      end
    end
    @(negedge clk); set_a(1'b0, 1'b0, 7'd0, 5'd0); set_b(1'b0, 1'b0, 7'd0, 5'd0);
    step(); step();
  endtask

  task automatic test_write_read();
    logic [AW-1:0] a, ra;
    logic [DW-1:0] d, e1, e2;
    @(negedge clk); set_a(1'b1, 1'b0, 7'b0010001, 5'b00001); ma[17] = 5'b00001;
    step();
    @(negedge clk); set_a(1'b0, 1'b1, 7'b0010001, 5'd0);
    step();
    tests_run++;
    if (bus_a.rd_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL wr_rd_early: got rdv=%b expected 0 on request edge", bus_a.rd_valid);
    end
    @(negedge clk); set_a(1'b0, 1'b0, 7'd0, 5'd0);
    step();
    tests_run++;
    if ({bus_a.rd_valid, bus_a.data_out} !== {1'b1, 5'b00001}) begin
      tests_failed++;
      $display("FAIL wr_rd_data: got rdv=%b dout=%h expected rdv=1 dout=01", bus_a.rd_valid, bus_a.data_out);
    end
    step();
    tests_run++;
    if ({bus_a.rd_valid, bus_a.data_out} !== {1'b0, 5'b00001}) begin
      tests_failed++;
      $display("FAIL wr_rd_hold: got rdv=%b dout=%h expected rdv=0 dout=01", bus_a.rd_valid, bus_a.data_out);
    end
    repeat (16) begin
      a = AW'($urandom_range(0, DEPTH_A - 1));
      ra = AW'($urandom_range(0, DEPTH_A - 1));
      d = DW'($urandom);
      ma[a] = d;
      e1 = d;
      e2 = ma[ra];
      @(negedge clk); set_a(1'b1, 1'b0, a, d);  step();
      @(negedge clk); set_a(1'b0, 1'b1, a, 5'd0); step();
      @(negedge clk); set_a(1'b0, 1'b1, ra, 5'd0); step();
      tests_run++;
      if ({bus_a.rd_valid, bus_a.data_out} !== {1'b1, e1}) begin
        tests_failed++;
        $display("FAIL raw_read @%0d: got rdv=%b dout=%h expected rdv=1 dout=%h", a, bus_a.rd_valid, bus_a.data_out, e1);
      end
      @(negedge clk); set_a(1'b0, 1'b0, 7'd0, 5'd0); step();
      tests_run++;
      if ({bus_a.rd_valid, bus_a.data_out} !== {1'b1, e2}) begin
        tests_failed++;
        $display("FAIL rand_read @%0d: got rdv=%b dout=%h expected rdv=1 dout=%h", ra, bus_a.rd_valid, bus_a.data_out, e2);
      end
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs [10];
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    @(negedge clk); set_b(1'b1, 1'b0, 7'b0110011, 5'b01000); mb[51] = 5'b01000; step();
    @(negedge clk); set_b(1'b1, 1'b0, 7'b0000000, 5'b10101); mb[0] = 5'b10101; step();
    @(negedge clk); set_b(1'b0, 1'b1, 7'b0110011, 5'd0); step();
    @(negedge clk); set_b(1'b0, 1'b1, 7'b0000000, 5'd0); step();
    tests_run++;
    if (bus_b.rd_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_early: got rdv=%b expected 0 one edge after first read", bus_b.rd_valid);
    end
    @(negedge clk); set_b(1'b0, 1'b0, 7'd0, 5'd0); step();
    tests_run++;
    if ({bus_b.rd_valid, bus_b.data_out} !== {1'b1, 5'b01000}) begin
      tests_failed++;
      $display("FAIL b2b_first: got rdv=%b dout=%h expected rdv=1 dout=08", bus_b.rd_valid, bus_b.data_out);
    end
    step();
    tests_run++;
    if ({bus_b.rd_valid, bus_b.data_out} !== {1'b1, 5'b10101}) begin
      tests_failed++;
      $display("FAIL b2b_second: got rdv=%b dout=%h expected rdv=1 dout=15", bus_b.rd_valid, bus_b.data_out);
    end
    step();
    tests_run++;
    if ({bus_b.rd_valid, bus_b.data_out} !== {1'b0, 5'b10101}) begin
      tests_failed++;
      $display("FAIL b2b_end: got rdv=%b dout=%h expected rdv=0 dout=15", bus_b.rd_valid, bus_b.data_out);
    end
    repeat (12) begin
      a = AW'($urandom_range(0, DEPTH_B - 1));
      d = DW'($urandom);
      mb[a] = d;
      @(negedge clk); set_b(1'b1, 1'b0, a, d); step();
    end
    foreach (addrs[i]) addrs[i] = AW'($urandom_range(0, DEPTH_B - 1));
    for (int i = 0; i < 10 + LAT_B; i++) begin
      @(negedge clk);
      if (i < 10) set_b(1'b0, 1'b1, addrs[i], 5'd0);
      else set_b(1'b0, 1'b0, 7'd0, 5'd0);
      step();
      if (i >= LAT_B) begin
        tests_run++;
        if ({bus_b.rd_valid, bus_b.data_out} !== {1'b1, mb[addrs[i-LAT_B]]}) begin
          tests_failed++;
          $display("FAIL burst_read[%0d] @%0d: got rdv=%b dout=%h expected rdv=1 dout=%h", i - LAT_B,
                   addrs[i-LAT_B], bus_b.rd_valid, bus_b.data_out, mb[addrs[i-LAT_B]]);
        end
      end
    end
    step();
  endtask

  task automatic test_conflict();
    @(negedge clk); set_a(1'b1, 1'b1, 7'd5, 5'b00111); ma[5] = 5'b00111; step();
    tests_run++;
    if ({bus_a.err, bus_a.rd_valid} !== 2'b10) begin
      tests_failed++;
      $display("FAIL conflict_err: got err=%b rdv=%b expected err=1 rdv=0", bus_a.err, bus_a.rd_valid);
    end
    @(negedge clk); set_a(1'b0, 1'b0, 7'd0, 5'd0); step();
    tests_run++;
    if ({bus_a.err, bus_a.rd_valid} !== 2'b00) begin
      tests_failed++;
      $display("FAIL conflict_drop: got err=%b rdv=%b expected err=0 rdv=0", bus_a.err, bus_a.rd_valid);
    end
    @(negedge clk); set_a(1'b0, 1'b1, 7'd5, 5'd0); step();
    @(negedge clk); set_a(1'b0, 1'b0, 7'd0, 5'd0); step();
    tests_run++;
    if ({bus_a.rd_valid, bus_a.data_out, bus_a.err} !== {1'b1, 5'b00111, 1'b0}) begin
      tests_failed++;
      $display("FAIL conflict_readback: got rdv=%b dout=%h err=%b expected rdv=1 dout=07 err=0",
               bus_a.rd_valid, bus_a.data_out, bus_a.err);
    end
    step();
  endtask

  task automatic test_out_of_range();
    @(negedge clk); set_b(1'b1, 1'b0, 7'd42, 5'h1f); mb[42] = 5'h1f; step();
    @(negedge clk); set_b(1'b0, 1'b1, 7'd42, 5'd0); step();
    @(negedge clk); set_b(1'b0, 1'b0, 7'd0, 5'd0); step(); step();
    @(negedge clk); set_b(1'b1, 1'b0, 7'd120, 5'b11111); step();
    tests_run++;
    if (bus_b.err !== 1'b1) begin
      tests_failed++;
      $display("FAIL oor_write_err: got err=%b expected 1", bus_b.err);
    end
    @(negedge clk); set_b(1'b0, 1'b1, 7'd120, 5'd0); step();
    tests_run++;
    if ({bus_b.err, bus_b.rd_valid} !== 2'b10) begin
      tests_failed++;
      $display("FAIL oor_read_err: got err=%b rdv=%b expected err=1 rdv=0", bus_b.err, bus_b.rd_valid);
    end
    @(negedge clk); set_b(1'b0, 1'b0, 7'd0, 5'd0); step();
    tests_run++;
    if ({bus_b.err, bus_b.rd_valid, bus_b.data_out} !== {1'b0, 1'b0, 5'h1f}) begin
      tests_failed++;
      $display("FAIL oor_gap: got err=%b rdv=%b dout=%h expected err=0 rdv=0 dout=1f",
               bus_b.err, bus_b.rd_valid, bus_b.data_out);
    end
    step();
    tests_run++;
    if ({bus_b.rd_valid, bus_b.data_out} !== {1'b1, 5'd0}) begin
      tests_failed++;
      $display("FAIL oor_read_data: got rdv=%b dout=%h expected rdv=1 dout=00", bus_b.rd_valid, bus_b.data_out);
    end
    @(negedge clk); set_b(1'b0, 1'b1, 7'd20, 5'd0); step();
    @(negedge clk); set_b(1'b0, 1'b1, 7'd56, 5'd0); step();
    @(negedge clk); set_b(1'b0, 1'b0, 7'd0, 5'd0); step();
    tests_run++;
    if ({bus_b.rd_valid, bus_b.data_out} !== {1'b1, mb[20]}) begin
      tests_failed++;
      $display("FAIL oor_alias20: got rdv=%b dout=%h expected rdv=1 dout=%h", bus_b.rd_valid, bus_b.data_out, mb[20]);
    end
    step();
    tests_run++;
    if ({bus_b.rd_valid, bus_b.data_out} !== {1'b1, mb[56]}) begin
      tests_failed++;
      $display("FAIL oor_alias56: got rdv=%b dout=%h expected rdv=1 dout=%h", bus_b.rd_valid, bus_b.data_out, mb[56]);
    end
    step();
  endtask

  task automatic test_random_traffic();
    int due_q[$];
    logic [DW-1:0] dat_q[$];
    logic w, r, exp_err, exp_v, known;
    logic [AW-1:0] addr;
    logic [DW-1:0] d, exp_d;
    known = 1'b0;
    exp_d = '0;
    for (int c = 1; c <= 300; c++) begin
      w = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 1) == 1);
      addr = AW'($urandom_range(0, 109));
      d = DW'($urandom);
      if (c > 290) begin w = 1'b0; r = 1'b0; end
      exp_err = (w && r) || ((w || r) && addr >= DEPTH_B);
      if (w && addr < DEPTH_B) mb[addr] = d;
      if (r && !w) begin
        due_q.push_back(c + LAT_B);
        dat_q.push_back((addr < DEPTH_B) ? mb[addr] : 5'd0);
      end
      @(negedge clk); set_b(w, r, addr, d); step();
      exp_v = (due_q.size() > 0 && due_q[0] == c);
      if (exp_v) begin
        void'(due_q.pop_front());
        exp_d = dat_q.pop_front();
        known = 1'b1;
      end
      tests_run++;
      if (bus_b.err !== exp_err || bus_b.rd_valid !== exp_v || (known && bus_b.data_out !== exp_d)) begin
        tests_failed++;
        $display("FAIL random_cycle %0d: got err=%b rdv=%b dout=%h expected err=%b rdv=%b dout=%h",
                 c, bus_b.err, bus_b.rd_valid, bus_b.data_out, exp_err, exp_v, exp_d);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    int cnt = 0;
    int done = 0;
    @(negedge clk); set_b(1'b1, 1'b0, 7'd7, 5'h16); mb[7] = 5'h16; step();
    @(negedge clk); set_b(1'b0, 1'b1, 7'd7, 5'd0); step();
    @(negedge clk); rst_b = 1'b0; set_b(1'b0, 1'b1, 7'd3, 5'd0); step();
    tests_run++;
    if ({bus_b.rd_valid, bus_b.data_out, bus_b.busy, bus_b.err} !== {1'b0, 5'd0, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL mid_reset_state: got rdv=%b dout=%h busy=%b err=%b expected 0/00/1/0",
               bus_b.rd_valid, bus_b.data_out, bus_b.busy, bus_b.err);
    end
    @(negedge clk); rst_b = 1'b1; set_b(1'b0, 1'b0, 7'd0, 5'd0); step(); cnt++;
    tests_run++;
    if ({bus_b.rd_valid, bus_b.busy} !== 2'b01) begin
      tests_failed++;
      $display("FAIL mid_reset_flush: got rdv=%b busy=%b expected rdv=0 busy=1", bus_b.rd_valid, bus_b.busy);
    end
    @(negedge clk); set_b(1'b1, 1'b0, 7'd90, 5'h1f); step(); cnt++;
    tests_run++;
    if ({bus_b.err, bus_b.rd_valid} !== 2'b10) begin
      tests_failed++;
      $display("FAIL clear_req_err: got err=%b rdv=%b expected err=1 rdv=0", bus_b.err, bus_b.rd_valid);
    end
    @(negedge clk); set_b(1'b0, 1'b0, 7'd0, 5'd0); step(); cnt++;
    tests_run++;
    if (bus_b.err !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_err_pulse: got err=%b expected 0", bus_b.err);
    end
    if (!bus_b.busy) done = cnt;
    while (done == 0 && cnt < 300) begin
      step(); cnt++;
      if (!bus_b.busy) done = cnt;
    end
    tests_run++;
    if (done != DEPTH_B) begin
      tests_failed++;
      $display("FAIL reclear_len: busy fell after %0d edges expected %0d", done, DEPTH_B);
    end
    foreach (mb[i]) mb[i] = '0;
    @(negedge clk); set_b(1'b0, 1'b1, 7'd7, 5'd0); step();
    @(negedge clk); set_b(1'b0, 1'b0, 7'd0, 5'd0); step(); step();
    tests_run++;
    if ({bus_b.rd_valid, bus_b.data_out} !== {1'b1, mb[7]}) begin
      tests_failed++;
      $display("FAIL reclear_read: got rdv=%b dout=%h expected rdv=1 dout=%h", bus_b.rd_valid, bus_b.data_out, mb[7]);
    end
  endtask

  initial begin
    set_a(1'b0, 1'b0, 7'd0, 5'd0);
    set_b(1'b0, 1'b0, 7'd0, 5'd0);
    test_reset();
    test_write_read();
    test_back_to_back();
    test_conflict();
    test_out_of_range();
    test_random_traffic();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
